// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and default widths for the CPU / loader memory port arbiter.
package mem_arb_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 9;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_ACCESS = ACCESS,
        ST_RESP   = RESP
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_LDR  = 2'd2
    } grant_e;

    localparam logic [3:0] WAIT_SAT = 4'd15;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == WAIT_SAT) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, RAM-side and status signals of the memory port arbiter.
// slave = arbiter view, master = environment (requesters + RAM) view.
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = mem_arb_pkg::DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = mem_arb_pkg::ADDR_WIDTH_DEF
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_ack;
    logic [DATA_WIDTH-1:0] cpu_rdata;

    logic                  ldr_req;
    logic                  ldr_we;
    logic [ADDR_WIDTH-1:0] ldr_addr;
    logic [DATA_WIDTH-1:0] ldr_wdata;
    logic                  ldr_ack;
    logic [DATA_WIDTH-1:0] ldr_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  mem_rdata,
        output cpu_ack, cpu_rdata, ldr_ack, ldr_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output mem_rdata,
        input  cpu_ack, cpu_rdata, ldr_ack, ldr_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: CPU has fixed priority over the loader; each access is IDLE -> ACCESS -> RESP.
// Optional loader aging guard enabled by defining MEM_PORT_ARBITER_AGING_EN.
//
// state  | meaning
// IDLE   | arbitrate current requests, latch winner's operands
// ACCESS | drive RAM enable/strobe from latched operands
// RESP   | pulse winner's ack, return read data
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int MAX_WAIT   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_port_arbiter_if.slave bus
);

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_max_wait_range
        $error("mem_port_arbiter: MAX_WAIT must be within 1..15");
    end

    state_e                state_q, state_d;
    grant_e                gnt_q, gnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  ldr_wins;
    logic                  in_access;
    logic                  in_resp;

`ifdef MEM_PORT_ARBITER_AGING_EN
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
    logic [3:0] wait_q, wait_d;

    // Loader is forced through once it has lost MAX_WAIT arbitrations in a row.
    assign ldr_wins = bus.ldr_req && (!bus.cpu_req || (wait_q >= MAX_WAIT_C));

    always_comb begin
        wait_d = wait_q;
        if (state_q == ST_IDLE) begin
            if (!bus.ldr_req || ldr_wins) begin
                wait_d = '0;
            end else begin
                wait_d = sat_inc(wait_q);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign ldr_wins = bus.ldr_req && !bus.cpu_req;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= GNT_NONE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                gnt_d = GNT_NONE;
                if (ldr_wins) begin
                    gnt_d   = GNT_LDR;
                    we_d    = bus.ldr_we;
                    addr_d  = bus.ldr_addr;
                    wdata_d = bus.ldr_wdata;
                    state_d = ST_ACCESS;
                end else if (bus.cpu_req) begin
                    gnt_d   = GNT_CPU;
                    we_d    = bus.cpu_we;
                    addr_d  = bus.cpu_addr;
                    wdata_d = bus.cpu_wdata;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP: begin
                gnt_d   = GNT_NONE;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = GNT_NONE;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode straight from the registered state so reset clears them immediately.
    assign in_access     = (state_q == ST_ACCESS);
    assign in_resp       = (state_q == ST_RESP);
    assign bus.mem_en    = in_access;
    assign bus.mem_we    = in_access && we_q;
    assign bus.mem_addr  = in_access ? addr_q : '0;
    assign bus.mem_wdata = in_access ? wdata_q : '0;
    assign bus.cpu_ack   = in_resp && (gnt_q == GNT_CPU);
    assign bus.ldr_ack   = in_resp && (gnt_q == GNT_LDR);
    assign bus.cpu_rdata = (bus.cpu_ack && !we_q) ? bus.mem_rdata : '0;
    assign bus.ldr_rdata = (bus.ldr_ack && !we_q) ? bus.mem_rdata : '0;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a slot-level reference model predicts RAM accesses and acks.
module tb_mem_port_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 9;
    localparam int MAXW = 4;
    localparam int WHO_CPU = 1;
    localparam int WHO_LDR = 2;
`ifdef MEM_PORT_ARBITER_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_port_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MAX_WAIT  (MAXW)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            due;
    } acc_t;

    typedef struct {
        int            who;
        logic [DW-1:0] rdata;
        int            due;
    } rsp_t;

    acc_t          acc_q[$];
    rsp_t          rsp_q[$];
    int            grant_log[$];
    logic [DW-1:0] ref_mem [512];
    logic [DW-1:0] ram [512];

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   slots_busy = 0;
    int   lost = 0;
    int   last_ldr_gnt = -1;
    int   n_cpu_ack = 0;
    int   n_ldr_ack = 0;
    int   n_mem_acc = 0;
    int   last_cpu_ack_cyc = 0;
    int   last_ldr_ack_cyc = 0;
    logic [DW-1:0] last_cpu_rdata = '0;
    bit   cpu_ack_n = 1'b0;
    bit   ldr_ack_n = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Synchronous RAM: read data appears one cycle after a read enable.
    initial begin
        for (int i = 0; i < 512; i++) ram[i] = '0;
        bus.mem_rdata <= '0;
        forever begin
            @(posedge clk);
            if (bus.mem_en) begin
                if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
                else            bus.mem_rdata <= ram[bus.mem_addr];
            end
        end
    end

    // Reference model: one arbitration slot opens every time the port has been free for a cycle.
    acc_t mdl_a;
    rsp_t mdl_r;
    bit   mdl_lw;
    initial begin
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset_n) begin
                acc_q.delete();
                rsp_q.delete();
                slots_busy = 0;
                lost = 0;
            end else if (slots_busy > 0) begin
                slots_busy--;
            end else if (bus.cpu_req || bus.ldr_req) begin
                mdl_lw = bus.ldr_req && (!bus.cpu_req || (AGING && lost >= MAXW));
                if (mdl_lw || !bus.ldr_req) lost = 0;
                else if (lost < 15)         lost++;
                mdl_a.we    = mdl_lw ? bus.ldr_we    : bus.cpu_we;
                mdl_a.addr  = mdl_lw ? bus.ldr_addr  : bus.cpu_addr;
                mdl_a.wdata = mdl_lw ? bus.ldr_wdata : bus.cpu_wdata;
                mdl_a.due   = cyc;
                mdl_r.who   = mdl_lw ? WHO_LDR : WHO_CPU;
                mdl_r.due   = cyc + 1;
                if (mdl_a.we) begin
                    ref_mem[mdl_a.addr] = mdl_a.wdata;
                    mdl_r.rdata = '0;
                end else begin
                    mdl_r.rdata = ref_mem[mdl_a.addr];
                end
                acc_q.push_back(mdl_a);
                rsp_q.push_back(mdl_r);
                grant_log.push_back(mdl_r.who);
                if (mdl_lw) last_ldr_gnt = cyc;
                slots_busy = 2;
            end else begin
                lost = 0;
            end
        end
    end

    // Monitor: compares DUT outputs against queued expectations at mid-cycle.
    acc_t mon_a;
    rsp_t mon_r;
    initial begin
        forever begin
            @(negedge clk);
            cpu_ack_n = bus.cpu_ack;
            ldr_ack_n = bus.ldr_ack;
            if (!reset_n) begin
                check("reset_outputs_zero", |{bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                      bus.cpu_ack, bus.cpu_rdata, bus.ldr_ack, bus.ldr_rdata, bus.busy}, 0);
            end else begin
                check("busy", bus.busy, slots_busy != 0);
                if (bus.mem_en) begin
                    n_mem_acc++;
                    if (acc_q.size() == 0) begin
                        check("unexpected_mem_access", bus.mem_en, 0);
                    end else begin
                        mon_a = acc_q.pop_front();
                        check("mem_cycle", cyc, mon_a.due);
                        check("mem_we", bus.mem_we, mon_a.we);
                        check("mem_addr", bus.mem_addr, mon_a.addr);
                        check("mem_wdata", bus.mem_wdata, mon_a.wdata);
                    end
                end else if (acc_q.size() != 0 && acc_q[0].due <= cyc) begin
                    check("mem_access_missing", bus.mem_en, 1);
                    void'(acc_q.pop_front());
                end
                if (bus.cpu_ack || bus.ldr_ack) begin
                    check("ack_exclusive", bus.cpu_ack & bus.ldr_ack, 0);
                    if (bus.cpu_ack) begin
                        n_cpu_ack++;
                        last_cpu_ack_cyc = cyc;
                        last_cpu_rdata = bus.cpu_rdata;
                    end else begin
                        n_ldr_ack++;
                        last_ldr_ack_cyc = cyc;
                    end
                    if (rsp_q.size() == 0) begin
                        check("unexpected_ack", bus.cpu_ack | bus.ldr_ack, 0);
                    end else begin
                        mon_r = rsp_q.pop_front();
                        check("ack_who", bus.cpu_ack ? WHO_CPU : WHO_LDR, mon_r.who);
                        check("ack_cycle", cyc, mon_r.due);
                        if (bus.cpu_ack) begin
                            check("cpu_rdata", bus.cpu_rdata, mon_r.rdata);
                            check("ldr_rdata_quiet", bus.ldr_rdata, 0);
                        end else begin
                            check("ldr_rdata", bus.ldr_rdata, mon_r.rdata);
                            check("cpu_rdata_quiet", bus.cpu_rdata, 0);
                        end
                    end
                end else begin
                    check("rdata_quiet", {bus.cpu_rdata, bus.ldr_rdata}, 0);
                    if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
                        check("ack_missing", bus.cpu_ack | bus.ldr_ack, 1);
                        void'(rsp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic drive(input int who, input logic req, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (who == WHO_CPU) begin
            bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        end else begin
            bus.ldr_req = req; bus.ldr_we = we; bus.ldr_addr = a; bus.ldr_wdata = d;
        end
    endtask

    task automatic wait_ack(input int who);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk); #1;
            done = (who == WHO_CPU) ? cpu_ack_n : ldr_ack_n;
        end
        if (!done) check("ack_timeout", done, 1);
    endtask

    task automatic issue(input int who, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        drive(who, 1'b1, we, a, d);
        wait_ack(who);
        drive(who, 1'b0, we, a, d);
    endtask

    task automatic wait_busy2();
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            seen = (slots_busy == 2);
        end
        if (!seen) check("grant_timeout", seen, 1);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 15));
        return a;
    endfunction

    initial begin
        int s;
        int n0;
        int acc0;
        int ack0;
        drive(WHO_CPU, 1'b0, 1'b0, '0, '0);
        drive(WHO_LDR, 1'b0, 1'b0, '0, '0);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // CPU write then read back, with request-to-ack latency of two cycles.
        s = cyc;
        issue(WHO_CPU, 1'b1, 9'h005, 32'hDEADBEEF);
        check("cpu_write_latency", last_cpu_ack_cyc - s, 2);
        s = cyc;
        issue(WHO_CPU, 1'b0, 9'h005, 32'h0);
        check("cpu_read_latency", last_cpu_ack_cyc - s, 2);
        check("cpu_readback", last_cpu_rdata, 32'hDEADBEEF);

        // Simultaneous requests: CPU first, loader three cycles later.
        repeat (2) @(posedge clk);
        #1;
        s = cyc;
        fork
            issue(WHO_CPU, 1'b0, 9'h010, 32'h0);
            issue(WHO_LDR, 1'b1, 9'h1FF, 32'hA5A5_0001);
        join
        check("sim_cpu_ack_at_n2", last_cpu_ack_cyc - s, 2);
        check("sim_ldr_ack_at_n5", last_ldr_ack_cyc - s, 5);

        // Operand latching: address change during ACCESS must not reach the RAM.
        repeat (2) @(posedge clk);
        #1;
        drive(WHO_CPU, 1'b1, 1'b0, 9'h020, 32'h0);
        wait_busy2();
        drive(WHO_CPU, 1'b1, 1'b0, 9'h030, 32'h0);
        #1;
        check("latched_mem_addr", bus.mem_addr, 9'h020);
        wait_ack(WHO_CPU);
        drive(WHO_CPU, 1'b0, 1'b0, 9'h030, 32'h0);

        // Withdrawn loader request during CPU ACCESS.
        repeat (2) @(posedge clk);
        #1;
        acc0 = n_mem_acc;
        ack0 = n_ldr_ack;
        fork
            issue(WHO_CPU, 1'b1, 9'h040, 32'h1234_5678);
            begin
                wait_busy2();
                drive(WHO_LDR, 1'b1, 1'b1, 9'h0AA, 32'h5555_5555);
                @(posedge clk); #1;
                drive(WHO_LDR, 1'b0, 1'b1, 9'h0AA, 32'h5555_5555);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check("withdraw_no_ldr_ack", n_ldr_ack - ack0, 0);
        check("withdraw_one_access", n_mem_acc - acc0, 1);

        // Reset while in ACCESS: outputs drop at once, no ack follows.
        ack0 = n_cpu_ack;
        drive(WHO_CPU, 1'b1, 1'b0, 9'h005, 32'h0);
        wait_busy2();
        #1 reset_n = 1'b0;
        #1;
        check("midreset_mem_en", bus.mem_en, 0);
        check("midreset_busy", bus.busy, 0);
        check("midreset_cpu_ack", bus.cpu_ack, 0);
        drive(WHO_CPU, 1'b0, 1'b0, 9'h005, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("midreset_no_ack", n_cpu_ack - ack0, 0);
        check("post_reset_idle", {bus.mem_en, bus.busy, bus.cpu_ack, bus.ldr_ack}, 0);

`ifdef MEM_PORT_ARBITER_AGING_EN
        // Both held high: four CPU grants, then the loader, repeating.
        n0 = grant_log.size();
        fork
            repeat (10) issue(WHO_CPU, 1'b0, rand_addr(), $urandom);
            repeat (2) issue(WHO_LDR, 1'b1, rand_addr(), $urandom);
        join
        for (int i = 0; i < 10; i++) begin
            if (n0 + i < grant_log.size())
                check($sformatf("aging_grant_%0d", i), grant_log[n0 + i], ((i % 5) == 4) ? WHO_LDR : WHO_CPU);
            else
                check($sformatf("aging_grant_%0d_present", i), grant_log.size(), n0 + i + 1);
        end
        repeat (2) @(posedge clk);
        #1;
`endif

        // Randomised traffic with loader withdrawals.
        fork
            repeat (60) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                issue(WHO_CPU, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            end
            repeat (40) begin
                repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
                if ($urandom_range(0, 3) == 0) begin
                    drive(WHO_LDR, 1'b1, 1'b1, rand_addr(), $urandom);
                    @(posedge clk); #1;
                    if (last_ldr_gnt == cyc) wait_ack(WHO_LDR);
                    drive(WHO_LDR, 1'b0, 1'b0, '0, '0);
                end else begin
                    issue(WHO_LDR, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
                end
            end
        join
        repeat (6) @(posedge clk);
        #1;
        check("scoreboard_drained", acc_q.size() + rsp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 512x32 synchronous RAM between two requesters:
  - the CPU control/datapath (fetch, load, store);
  - the debug/program-loader port.
- Sits between both requesters and the RAM. All RAM control (en, we, addr, wdata) comes from this block.
- Three-phase FSM per access. CPU has fixed priority. An optional aging guard bounds loader starvation.

Parameters:
- DATA_WIDTH, 32, RAM word width.
- ADDR_WIDTH, 9, RAM address width (512 words).
- MAX_WAIT, 4, consecutive lost arbitrations after which the loader wins the next one (aging feature only; legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_WIDTH  CPU word address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_WIDTH  read data; valid only while cpu_ack is high.
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_ack, ldr_rdata  same meanings, loader side.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write strobe.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM read data; registered, valid one cycle after mem_en with mem_we=0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - state = IDLE; grant = NONE; wait counter = 0.
  - All outputs 0, including mem_en, mem_we, acks, rdata and busy.
- States:
  - IDLE: arbitrate on the current req inputs.
    - No req: stay in IDLE.
    - Otherwise latch grant, we, addr and wdata of the winner, then go to ACCESS.
  - ACCESS: mem_en=1; mem_we/mem_addr/mem_wdata come from the latched values. Go to RESP.
  - RESP: mem_en=0 and mem_we=0. Pulse the winner's ack. The winner's rdata = mem_rdata for a read, 0 for a write. Go to IDLE.
- Latency: req sampled high in IDLE at cycle N -> RAM access at N+1 -> ack at N+2. Throughput is one access per 3 cycles.
- Latched operands: changes on the winner's inputs after cycle N are ignored for that access.
- Requester rules:
  - Keep req, we, addr and wdata stable until ack.
  - Deassert req in the cycle after ack, or hold it to issue the next access. A held req is re-arbitrated in the following IDLE.
  - A req dropped before it is granted is withdrawn silently. No ack is ever issued without a grant.
- Arbitration:
  - Both requesting in IDLE: CPU wins, unless aging forces the loader.
  - Single requester: it wins immediately.
  - The loser's inputs are untouched; it is re-arbitrated at the next IDLE.
- Non-winner outputs: ack and rdata stay 0 in every cycle.
- Reset mid-operation (ACCESS or RESP):
  - Returns to IDLE immediately; no ack is issued.
  - A write already strobed in ACCESS may have completed in RAM. Requesters must reissue the access.
- Both acks are never high in the same cycle.

Optional Feature:
- MEM_PORT_ARBITER_AGING_EN
- Defined:
  - 4-bit wait counter increments each IDLE arbitration where ldr_req=1 and the CPU wins. It saturates at 15.
  - When counter >= MAX_WAIT, the loader wins the next arbitration even if cpu_req=1.
  - Counter clears when the loader is granted, or when ldr_req=0 in IDLE.
- Not defined: strict CPU priority; no counter logic is present.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding localparams: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2;
  - grant encoding: GNT_NONE, GNT_CPU, GNT_LDR;
  - default widths (DATA_WIDTH 32, ADDR_WIDTH 9).
- No sub-module: FSM, operand latch and aging counter stay in one module.
- The aging counter is guarded inline by the macro.

Test Plan:
- Reset: assert reset_n=0 mid-ACCESS -> same cycle mem_en=0, busy=0, state IDLE, no ack; after release, idle outputs stay all 0.
- CPU write then read:
  - cpu_req, we=1, addr=0x005, wdata=0xDEADBEEF -> mem_en/mem_we high exactly 1 cycle; cpu_ack 2 cycles after req.
  - Read addr=0x005 -> cpu_rdata=0xDEADBEEF with cpu_ack.
- Simultaneous requests:
  - cpu addr=0x010 and ldr addr=0x1FF both requesting at cycle N, aging off -> CPU ack at N+2, loader ack at N+5.
  - No cycle has both acks high.
- Operand latching: change cpu_addr from 0x020 to 0x030 one cycle after grant -> mem_addr=0x020 during ACCESS.
- Withdrawn request: ldr_req pulses 1 cycle while the CPU is in ACCESS -> no ldr_ack, no loader RAM access.
- Aging, MEM_PORT_ARBITER_AGING_EN, MAX_WAIT=4:
  - cpu_req and ldr_req held high -> the loader is granted on the 5th arbitration.
  - Counter then resets; the pattern repeats (4 CPU grants, 1 loader grant).
